// File: rtl/clksel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clksel_pkg
// Description : Shared types for the CPU clock-switch initiator.
//               - state_t : handshake FSM encoding (also exported on state_o)
//               - div_t   : CPU clock divider codes
//               - hs_settled / ls_settled : "controller has finished switching"
// Revision    : 1.0 - initial release
// ============================================================================
package clksel_pkg;

    typedef enum logic [1:0] {
        LS_RUN = 2'b00,
        TO_HS  = 2'b01,
        HS_RUN = 2'b10,
        TO_LS  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        DIV1 = 2'b00,
        DIV2 = 2'b01,
        DIV4 = 2'b10,
        DIV8 = 2'b11
    } div_t;

    // A switch is only complete when exactly one status is asserted; both
    // high (or a glitch on one) means the controller is still mid-switch.
    function automatic logic hs_settled(input logic hs, input logic ls);
        return hs & ~ls;
    endfunction

    function automatic logic ls_settled(input logic hs, input logic ls);
        return ls & ~hs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clksel_sequencer_sync.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Single-bit multi-flop synchroniser, cleared by reset.
// Ports       : clk  - destination clock
//               rst  - synchronous active-high reset
//               i_d  - asynchronous input
//               o_q  - synchronised output (STAGES flops later)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/clksel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : clksel_sequencer
// Description : Initiator side of the CPU clock-switch handshake. Turns
//               per-bus-cycle decode strobes into hsclk_sel requests, tracks
//               the synchronised controller status and stalls the CPU (rdy=0)
//               until each requested switch has completed. Divider writes are
//               applied directly in LS_RUN or deferred to the next LS entry.
// Ports       : hsclk_in          - block clock
//               rst               - synchronous active-high reset
//               req_valid/req_hs  - decode strobe and fast/slow result
//               div_sel_in/_wr    - divider value and write strobe
//               hsclk_selected_in - async controller status (HS active)
//               lsclk_selected_in - async controller status (LS active)
//               err_clr           - clears switch_err
//               hsclk_sel         - HS clock request (registered)
//               cpuclk_div_sel    - divider select (registered)
//               rdy               - CPU ready, 0 = stall (registered)
//               switch_err        - sticky switch timeout flag
//               state_o           - FSM state for debug
// Revision    : 1.0 - initial release
// ============================================================================
module clksel_sequencer
    import clksel_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         TIMEOUT     = 4000,
    parameter int         TIMEOUT_W   = 12,
    parameter int         LS_MIN      = 8,
    parameter logic [1:0] DIV_RESET   = DIV8
) (
    input  logic       hsclk_in,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_hs,
    input  logic [1:0] div_sel_in,
    input  logic       div_sel_wr,
    input  logic       hsclk_selected_in,
    input  logic       lsclk_selected_in,
    input  logic       err_clr,
    output logic       hsclk_sel,
    output logic [1:0] cpuclk_div_sel,
    output logic       rdy,
    output logic       switch_err,
    output logic [1:0] state_o
);

    // +2 keeps the dwell counter at least one bit wide even for LS_MIN=0
    localparam int DW_W = $clog2(LS_MIN + 2);

    localparam logic [TIMEOUT_W-1:0] c_TMR_ONE  = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] c_TMR_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [DW_W-1:0]      c_DW_ONE   = DW_W'(1);
    localparam logic [DW_W-1:0]      c_DW_LOAD  = DW_W'(LS_MIN);

    // ------------------------------------------------------------------
    // Status synchronisers
    // ------------------------------------------------------------------
    logic w_hs_s;
    logic w_ls_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_hs (
        .clk (hsclk_in),
        .rst (rst),
        .i_d (hsclk_selected_in),
        .o_q (w_hs_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ls (
        .clk (hsclk_in),
        .rst (rst),
        .i_d (lsclk_selected_in),
        .o_q (w_ls_s)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t               r_state,        w_state_nxt;
    logic                 r_hsclk_sel,    w_hsclk_sel_nxt;
    logic                 r_rdy,          w_rdy_nxt;
    logic [1:0]           r_div,          w_div_nxt;
    logic                 r_err,          w_err_nxt;
    logic [TIMEOUT_W-1:0] r_timer,        w_timer_nxt;
    logic [DW_W-1:0]      r_dwell,        w_dwell_nxt;
    logic                 r_pend_hs,      w_pend_hs_nxt;
    logic [1:0]           r_div_pend,     w_div_pend_nxt;
    logic                 r_div_pend_vld, w_div_pend_vld_nxt;

    // Strobes are only honoured while the CPU is running; a stalled CPU
    // cannot issue a real bus cycle.
    logic w_req_hs;
    logic w_req_ls;
    logic w_tmo;

    assign w_req_hs = req_valid &  req_hs & r_rdy;
    assign w_req_ls = req_valid & ~req_hs & r_rdy;
    assign w_tmo    = (r_timer == c_TMR_LAST);

    always_ff @(posedge hsclk_in) begin
        if (rst) begin
            r_state        <= LS_RUN;
            r_hsclk_sel    <= 1'b0;
            r_rdy          <= 1'b1;
            r_div          <= DIV_RESET;
            r_err          <= 1'b0;
            r_timer        <= '0;
            r_dwell        <= '0;
            r_pend_hs      <= 1'b0;
            r_div_pend     <= '0;
            r_div_pend_vld <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_hsclk_sel    <= w_hsclk_sel_nxt;
            r_rdy          <= w_rdy_nxt;
            r_div          <= w_div_nxt;
            r_err          <= w_err_nxt;
            r_timer        <= w_timer_nxt;
            r_dwell        <= w_dwell_nxt;
            r_pend_hs      <= w_pend_hs_nxt;
            r_div_pend     <= w_div_pend_nxt;
            r_div_pend_vld <= w_div_pend_vld_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_hsclk_sel_nxt    = r_hsclk_sel;
        w_rdy_nxt          = r_rdy;
        w_div_nxt          = r_div;
        w_err_nxt          = r_err & ~err_clr;
        w_timer_nxt        = r_timer;
        w_dwell_nxt        = (r_dwell != '0) ? (r_dwell - c_DW_ONE) : r_dwell;
        w_pend_hs_nxt      = r_pend_hs;
        w_div_pend_nxt     = r_div_pend;
        w_div_pend_vld_nxt = r_div_pend_vld;

        // The divider may only change while the CPU runs on the slow clock
        // with no switch queued; otherwise park the value (last write wins).
        if (div_sel_wr) begin
            if ((r_state == LS_RUN) && !r_pend_hs) begin
                w_div_nxt = div_sel_in;
            end else begin
                w_div_pend_nxt     = div_sel_in;
                w_div_pend_vld_nxt = 1'b1;
            end
        end

        case (r_state)
            LS_RUN: begin
                if (w_req_hs) begin
                    if (r_dwell == '0) begin
                        w_state_nxt     = TO_HS;
                        w_hsclk_sel_nxt = 1'b1;
                        w_rdy_nxt       = 1'b0;
                        w_timer_nxt     = '0;
                    end else begin
                        w_pend_hs_nxt = 1'b1;
                        w_rdy_nxt     = 1'b0;
                    end
                end else if (r_pend_hs && (r_dwell <= c_DW_ONE)) begin
                    // Dwell reaches zero on this edge: launch the queued switch
                    w_state_nxt     = TO_HS;
                    w_hsclk_sel_nxt = 1'b1;
                    w_rdy_nxt       = 1'b0;
                    w_timer_nxt     = '0;
                    w_pend_hs_nxt   = 1'b0;
                end
            end

            TO_HS: begin
                w_timer_nxt = r_timer + c_TMR_ONE;
                if (hs_settled(w_hs_s, w_ls_s)) begin
                    w_state_nxt = HS_RUN;
                    w_rdy_nxt   = 1'b1;
                end else if (w_tmo) begin
                    // Controller never confirmed HS: fall back to the safe clock
                    w_err_nxt       = 1'b1;
                    w_hsclk_sel_nxt = 1'b0;
                    w_timer_nxt     = '0;
                    w_state_nxt     = TO_LS;
                end
            end

            HS_RUN: begin
                if (w_req_ls) begin
                    w_state_nxt     = TO_LS;
                    w_hsclk_sel_nxt = 1'b0;
                    w_rdy_nxt       = 1'b0;
                    w_timer_nxt     = '0;
                end
            end

            TO_LS: begin
                w_timer_nxt = r_timer + c_TMR_ONE;
                if (ls_settled(w_hs_s, w_ls_s)) begin
                    w_state_nxt        = LS_RUN;
                    w_rdy_nxt          = 1'b1;
                    w_dwell_nxt        = c_DW_LOAD;
                    w_div_pend_vld_nxt = 1'b0;
                    // A write arriving on the entry edge is newer than div_pend
                    if (div_sel_wr) begin
                        w_div_nxt = div_sel_in;
                    end else if (r_div_pend_vld) begin
                        w_div_nxt = r_div_pend;
                    end
                end else if (w_tmo) begin
                    // LS is the only safe clock, so keep waiting and flag it
                    w_err_nxt   = 1'b1;
                    w_timer_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = LS_RUN;
            end
        endcase
    end

    assign hsclk_sel      = r_hsclk_sel;
    assign cpuclk_div_sel = r_div;
    assign rdy            = r_rdy;
    assign switch_err     = r_err;
    assign state_o        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clksel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_clksel_sequencer
// Description : Self-checking bench for clksel_sequencer. A table of
//               per-cycle stimulus/expected-output records walks through the
//               LS->HS->LS handshake, dwell, divider deferral, reset and
//               glitch cases; hand-written sequences cover the TO_LS timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clksel_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_hs = 1'b0;
    logic [1:0] div_sel_in = 2'b00;
    logic       div_sel_wr = 1'b0;
    logic       hs_in = 1'b0;
    logic       ls_in = 1'b1;
    logic       err_clr = 1'b0;
    logic       hsclk_sel;
    logic [1:0] cpuclk_div_sel;
    logic       rdy;
    logic       switch_err;
    logic [1:0] state_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    clksel_sequencer #(
        .SYNC_STAGES (2),
        .TIMEOUT     (16),
        .TIMEOUT_W   (5),
        .LS_MIN      (8),
        .DIV_RESET   (2'b11)
    ) dut (
        .hsclk_in          (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_hs            (req_hs),
        .div_sel_in        (div_sel_in),
        .div_sel_wr        (div_sel_wr),
        .hsclk_selected_in (hs_in),
        .lsclk_selected_in (ls_in),
        .err_clr           (err_clr),
        .hsclk_sel         (hsclk_sel),
        .cpuclk_div_sel    (cpuclk_div_sel),
        .rdy               (rdy),
        .switch_err        (switch_err),
        .state_o           (state_o)
    );

    typedef struct {
        logic       v, h, w;
        logic [1:0] d;
        logic       hs, ls, r, c;
        logic [1:0] st;
        logic       sel, rdy;
        logic [1:0] div;
        logic       err;
    } vec_t;

    vec_t tbl [64];
    int   ntbl = 0;

    task automatic add(input logic v, input logic h, input logic w, input logic [1:0] d,
                       input logic hs, input logic ls, input logic r, input logic c,
                       input logic [1:0] st, input logic sel, input logic rd,
                       input logic [1:0] div, input logic err);
        tbl[ntbl].v   = v;   tbl[ntbl].h   = h;   tbl[ntbl].w = w;  tbl[ntbl].d = d;
        tbl[ntbl].hs  = hs;  tbl[ntbl].ls  = ls;  tbl[ntbl].r = r;  tbl[ntbl].c = c;
        tbl[ntbl].st  = st;  tbl[ntbl].sel = sel; tbl[ntbl].rdy = rd;
        tbl[ntbl].div = div; tbl[ntbl].err = err;
        ntbl++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // {state, hsclk_sel, rdy, div, err}
    function automatic logic [7:0] outs();
        return {1'b0, state_o, hsclk_sel, rdy, cpuclk_div_sel, switch_err};
    endfunction

    initial begin
        // v h w d  hs ls r c   st sel rdy div err
        add(0,0,0,0, 0,1, 1,0,  0, 0, 1, 3, 0);          // reset
        repeat (2) add(0,0,0,0, 0,1, 0,0, 0, 0, 1, 3, 0);
        add(0,0,1,2, 0,1, 0,0,  0, 0, 1, 2, 0);          // direct div write
        add(1,0,0,0, 0,1, 0,0,  0, 0, 1, 2, 0);          // slow strobe: no action
        add(1,1,0,0, 0,1, 0,0,  1, 1, 0, 2, 0);          // HS request
        repeat (2) add(0,0,0,0, 0,1, 0,0, 1, 1, 0, 2, 0);
        repeat (2) add(0,0,0,0, 1,0, 0,0, 1, 1, 0, 2, 0); // status swap, syncing
        add(0,0,0,0, 1,0, 0,0,  2, 1, 1, 2, 0);          // HS_RUN, third edge
        add(1,1,0,0, 1,0, 0,0,  2, 1, 1, 2, 0);          // fast strobe in HS: no action
        add(0,0,1,1, 1,0, 0,0,  2, 1, 1, 2, 0);          // deferred div write
        add(1,0,0,0, 1,0, 0,0,  3, 0, 0, 2, 0);          // LS request
        repeat (2) add(0,0,0,0, 0,1, 0,0, 3, 0, 0, 2, 0);
        add(0,0,0,0, 0,1, 0,0,  0, 0, 1, 1, 0);          // LS entry applies div_pend
        add(0,0,0,0, 0,1, 0,0,  0, 0, 1, 1, 0);
        add(1,1,0,0, 0,1, 0,0,  0, 0, 0, 1, 0);          // dwell active: pend
        add(0,0,0,0, 0,1, 0,0,  0, 0, 0, 1, 0);
        add(1,0,0,0, 0,1, 0,0,  0, 0, 0, 1, 0);          // ignored, rdy=0
        add(0,0,1,0, 0,1, 0,0,  0, 0, 0, 1, 0);          // write deferred while pending
        add(1,1,0,0, 0,1, 0,0,  0, 0, 0, 1, 0);
        add(0,0,0,0, 0,1, 0,0,  0, 0, 0, 1, 0);
        add(0,0,0,0, 0,1, 0,0,  1, 1, 0, 1, 0);          // dwell expired: TO_HS
        add(0,0,0,0, 0,1, 1,0,  0, 0, 1, 3, 0);          // reset mid TO_HS
        add(0,0,0,0, 0,1, 0,0,  0, 0, 1, 3, 0);
        add(1,1,1,0, 0,1, 0,0,  1, 1, 0, 0, 0);          // request + div write same edge
        add(0,0,0,0, 1,1, 0,0,  1, 1, 0, 0, 0);          // hs glitch, ls still high
        repeat (14) add(0,0,0,0, 0,1, 0,0, 1, 1, 0, 0, 0);
        add(0,0,0,0, 0,1, 0,1,  3, 0, 0, 0, 1);          // timeout beats err_clr
        add(0,0,0,0, 0,1, 0,0,  0, 0, 1, 0, 1);          // LS completes, err sticky
        add(0,0,0,0, 0,1, 0,1,  0, 0, 1, 0, 0);          // err_clr
        add(0,0,1,3, 0,1, 0,0,  0, 0, 1, 3, 0);
        add(1,1,0,0, 0,1, 0,0,  0, 0, 0, 3, 0);          // dwell still running

        for (int i = 0; i < ntbl; i++) begin
            req_valid  = tbl[i].v;
            req_hs     = tbl[i].h;
            div_sel_wr = tbl[i].w;
            div_sel_in = tbl[i].d;
            hs_in      = tbl[i].hs;
            ls_in      = tbl[i].ls;
            rst        = tbl[i].r;
            err_clr    = tbl[i].c;
            step();
            chk($sformatf("row%0d", i), outs(),
                {1'b0, tbl[i].st, tbl[i].sel, tbl[i].rdy, tbl[i].div, tbl[i].err});
        end

        // ---- TO_LS timeout: controller never confirms LS ----
        req_valid = 0; req_hs = 0; div_sel_wr = 0; err_clr = 0;
        rst = 1; hs_in = 0; ls_in = 1;
        step();
        rst = 0;
        step();
        step();
        req_valid = 1; req_hs = 1;
        step();
        req_valid = 0;
        chk("seq_to_hs", {4'b0, state_o, hsclk_sel, rdy}, {4'b0, 2'b01, 1'b1, 1'b0});
        hs_in = 1; ls_in = 0;
        step();
        step();
        chk("seq_hs_wait", {7'b0, rdy}, 8'd0);
        step();
        chk("seq_hs_run", {5'b0, state_o, rdy}, {5'b0, 2'b10, 1'b1});
        req_valid = 1; req_hs = 0;
        step();
        req_valid = 0;
        hs_in = 0; ls_in = 0;
        chk("seq_to_ls", {5'b0, state_o, rdy}, {5'b0, 2'b11, 1'b0});
        repeat (15) step();
        chk("seq_ls_pre_tmo", {7'b0, switch_err}, 8'd0);
        step();
        chk("seq_ls_tmo", outs(), {1'b0, 2'b11, 1'b0, 1'b0, 2'b11, 1'b1});
        repeat (20) step();
        chk("seq_ls_hold", {5'b0, state_o, rdy}, {5'b0, 2'b11, 1'b0});
        ls_in = 1;
        step();
        step();
        chk("seq_ls_sync", {6'b0, state_o}, {6'b0, 2'b11});
        step();
        chk("seq_ls_done", outs(), {1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 1'b1});
        err_clr = 1;
        step();
        err_clr = 0;
        chk("seq_err_clr", {7'b0, switch_err}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
